dmux_dispatch_ctrl: RTL and testbench
=====================================

Name: dmux_dispatch_ctrl

Overview:
Sequencing controller that owns an N-way demultiplexer and steers a single valid/ready input stream to one of N output lanes.
- Holds one word in an internal register and drives the select.
- Enforces the dmux rule: unselected lanes carry 0 on both valid and data.
- Two steering modes: round-robin with stall-based retargeting, or fixed destination.
- Sits between a single producer and N consumers, such as register-file write ports or memory banks.

Parameters:
WIDTH, 16, data word width in bits
SEL_W, 2, select width; lane count N = 2**SEL_W
STALL_MAX, 15, consecutive not-ready cycles before round-robin retarget (must be at least 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer has a word
in_ready  output  1  controller accepts the word this cycle
in_data  input  WIDTH  producer word
mode  input  1  0 = round-robin, 1 = fixed destination
dest_sel  input  SEL_W  destination lane when mode = 1; sampled at acceptance
flush  input  1  synchronous discard of the held word
out_valid  output  N  one-hot valid; bit k addresses lane k
out_ready  input  N  per-lane consumer ready
out_data  output  N*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]; unselected lanes are 0
sel_out  output  SEL_W  current target lane (the dmux select)
busy  output  1  a word is held
retarget  output  1  one-cycle pulse when a stalled word moves to a new lane

Behaviour:
- Reset (asynchronous, active-high). Returns to ST_IDLE and clears:
  - rr_ptr = 0, sel_out = 0, stall_cnt = 0, held data = 0
  - out_valid = 0, out_data = 0, busy = 0, retarget = 0
  - in_ready = 0 while reset is high.
  - Reset mid-transfer discards the held word with no output handshake.
- States:
  - ST_IDLE: in_ready = 1, busy = 0, out_valid = 0.
  - ST_HOLD: busy = 1; out_valid = 1 << sel_out; lane sel_out carries the held word.
- Acceptance: acc = in_valid & in_ready. On acc, the word is latched and the target is set:
  - mode = 1: target = dest_sel.
  - mode = 0: target = rr_ptr.
  - Next state is ST_HOLD.
- Latency: a word accepted at edge t appears on out_valid/out_data from cycle t+1. All outputs are registered, except in_ready, which is combinational.
- Transfer: xfer = ST_HOLD & out_ready[sel_out].
  - On xfer with mode = 0, rr_ptr = sel_out + 1 (wraps modulo N, SEL_W-bit natural wrap).
  - On xfer, stall_cnt = 0.
- Back-to-back throughput: in ST_HOLD, in_ready = out_ready[sel_out].
  - Simultaneous xfer and acc: load the new word and stay in ST_HOLD.
  - The new round-robin target uses the advanced pointer (sel_out + 1). Sustained throughput is 1 word per cycle.
  - xfer without acc: go to ST_IDLE.
- Stall (ST_HOLD and not out_ready[sel_out]): stall_cnt increments.
  - Round-robin retarget: when mode = 0 and stall_cnt reaches STALL_MAX, set sel_out = sel_out + 1 (wraps), clear stall_cnt, and pulse retarget for one cycle. The data is unchanged.
  - Fixed mode: never retargets; stall_cnt saturates at STALL_MAX.
  - rr_ptr does not move on retarget.
- Flush: takes priority over xfer/acc/retarget.
  - ST_HOLD goes to ST_IDLE, held data is cleared, stall_cnt = 0. rr_ptr is unchanged.
  - in_ready = 0 during flush, so no word is accepted.
- mode or dest_sel changing while in ST_HOLD has no effect on the held word.
- out_ready on unselected lanes is ignored.

Decomposition:
- Shared package: state localparams ST_IDLE = 1'b0 and ST_HOLD = 1'b1, and the lane-slice helper constant.
- Sub-module dmux_n_way (parameters WIDTH and SEL_W): combinational N-way demux that routes in to lane sel and zeroes all other lanes.
  - Instantiated twice: WIDTH = 1 for valid, WIDTH = WIDTH for data.
- The controller keeps the FSM, rr_ptr, stall_cnt and the hold register.

Test Plan:
- Reset mid-hold: accept 16'h00AA, then assert reset for 1 cycle -> out_valid = 0, busy = 0, sel_out = 0, in_ready = 0 during reset, 1 after.
- Round-robin sequence: mode = 0, all out_ready = 1, send 16'h0001..16'h0005 back-to-back -> lanes 0,1,2,3,0 in that order, one word per cycle, first output one cycle after the first acceptance; unselected lanes are 0.
- Fixed mode with backpressure: mode = 1, dest_sel = 2, out_ready[2] = 0 for 20 cycles then 1 -> out_valid = 4'b0100 held for 21 cycles, in_ready = 0 during stall, no retarget pulse, single transfer of the word.
- Retarget: mode = 0, rr_ptr = 1, out_ready = 4'b1101, send 16'hBEEF, STALL_MAX = 15 -> lane 1 valid for 15 cycles, retarget pulses, lane 2 takes 16'hBEEF, next word goes to lane 3.
- Flush vs transfer: in ST_HOLD on lane 0 with out_ready[0] = 1 and flush = 1 in the same cycle -> no transfer counted, state ST_IDLE, rr_ptr unchanged, next word goes to lane 0.

Source files
------------

// File: rtl/dmux_dispatch_ctrl_pkg.sv
// rtl/dmux_dispatch_ctrl_pkg.sv - shared state encoding and lane-slice helper for the dispatch controller
//
// Purpose : types and helpers shared by dmux_dispatch_ctrl and dmux_n_way.
// Contents: state_e  - controller state (ST_IDLE / ST_HOLD)
//           lane_lsb - bit offset of lane k inside a flattened N*WIDTH bus

package dmux_dispatch_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Lane k of a flattened bus occupies [lane_lsb(k, w) +: w].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dmux_n_way.sv
// rtl/dmux_n_way.sv - combinational N-way demultiplexer, unselected lanes driven to zero
//
// Purpose : routes in_word onto lane sel of a flattened output bus; every
//           other lane is forced to zero.
// Ports   : in_word [WIDTH-1:0]          - word to steer
//           sel     [SEL_W-1:0]          - destination lane
//           lanes   [N*WIDTH-1:0]        - lane k at [k*WIDTH +: WIDTH], N = 2**SEL_W

module dmux_n_way
  import dmux_dispatch_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2
) (
  input  logic [WIDTH-1:0]              in_word,
  input  logic [SEL_W-1:0]              sel,
  output logic [(2**SEL_W)*WIDTH-1:0]   lanes
);

  localparam int N = 2 ** SEL_W;

  always_comb begin
    lanes = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        lanes[lane_lsb(k, WIDTH) +: WIDTH] = in_word;
      end
    end
  end

endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// rtl/dmux_dispatch_ctrl.sv - single-word dispatch controller steering one stream onto N dmux lanes
//
// Purpose : accepts one word at a time from a valid/ready producer, holds it,
//           and presents it on one of N consumer lanes. Round-robin mode
//           walks the lanes and moves a stalled word to the next lane after
//           STALL_MAX blocked cycles; fixed mode sends to dest_sel.
// Ports   : clk, reset (async, active-high)
//           in_valid / in_ready / in_data     - producer side
//           mode (0 = round-robin, 1 = fixed), dest_sel, flush
//           out_valid[N] / out_ready[N] / out_data[N*WIDTH] - consumer lanes
//           sel_out (dmux select), busy (word held), retarget (1-cycle pulse)

module dmux_dispatch_ctrl
  import dmux_dispatch_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 2,
  parameter int STALL_MAX = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              dest_sel,
  input  logic                          flush,
  output logic [(2**SEL_W)-1:0]         out_valid,
  input  logic [(2**SEL_W)-1:0]         out_ready,
  output logic [(2**SEL_W)*WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]              sel_out,
  output logic                          busy,
  output logic                          retarget
);

  localparam int CNT_W = $clog2(STALL_MAX + 1);

  state_e             state_q,     state_d;
  logic [SEL_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [SEL_W-1:0]   sel_q,       sel_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0]   data_q,      data_d;
  logic               mode_q,      mode_d;
  logic               retarget_q,  retarget_d;

  logic               hold;
  logic               lane_ready;
  logic               acc;
  logic               xfer;
  logic [SEL_W-1:0]   rr_after;

  assign hold       = (state_q == ST_HOLD);
  assign lane_ready = out_ready[sel_q];

  // Only the selected lane's ready matters; in HOLD the slot frees up in the
  // same cycle the consumer takes the word, giving one word per cycle.
  assign in_ready = !reset && !flush && (!hold || lane_ready);
  assign acc      = in_valid && in_ready;
  assign xfer     = hold && lane_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    stall_cnt_d = stall_cnt_q;
    data_d      = data_q;
    mode_d      = mode_q;
    retarget_d  = 1'b0;
    // The round-robin pointer only advances past words sent in round-robin mode.
    rr_after    = mode_q ? rr_ptr_q : sel_q + SEL_W'(1);

    if (flush) begin
      state_d     = ST_IDLE;
      data_d      = '0;
      stall_cnt_d = '0;
    end else if (hold) begin
      if (xfer) begin
        stall_cnt_d = '0;
        rr_ptr_d    = rr_after;
        if (acc) begin
          data_d = in_data;
          mode_d = mode;
          sel_d  = mode ? dest_sel : rr_after;
        end else begin
          state_d = ST_IDLE;
          data_d  = '0;
        end
      end else if (!mode_q && (stall_cnt_q == CNT_W'(STALL_MAX - 1))) begin
        // This stalled cycle is the STALL_MAX-th: move the word to the next lane.
        sel_d       = sel_q + SEL_W'(1);
        stall_cnt_d = '0;
        retarget_d  = 1'b1;
      end else if (stall_cnt_q != CNT_W'(STALL_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (acc) begin
      state_d     = ST_HOLD;
      data_d      = in_data;
      mode_d      = mode;
      sel_d       = mode ? dest_sel : rr_ptr_q;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      stall_cnt_q <= '0;
      data_q      <= '0;
      mode_q      <= 1'b0;
      retarget_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      stall_cnt_q <= stall_cnt_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      retarget_q  <= retarget_d;
    end
  end

  assign sel_out  = sel_q;
  assign busy     = hold;
  assign retarget = retarget_q;

  dmux_n_way #(
    .WIDTH (1),
    .SEL_W (SEL_W)
  ) u_valid_dmux (
    .in_word (hold),
    .sel     (sel_q),
    .lanes   (out_valid)
  );

  // data_q is cleared whenever the controller leaves HOLD, so the selected
  // lane also reads zero while idle.
  dmux_n_way #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_data_dmux (
    .in_word (data_q),
    .sel     (sel_q),
    .lanes   (out_data)
  );

endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb/tb_dmux_dispatch_ctrl.sv - scoreboard bench for dmux_dispatch_ctrl

module tb_dmux_dispatch_ctrl;

  localparam int WIDTH     = 16;
  localparam int SEL_W     = 2;
  localparam int N         = 4;
  localparam int STALL_MAX = 15;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 mode = 1'b0;
  logic [SEL_W-1:0]     dest_sel = '0;
  logic                 flush = 1'b0;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready = '0;
  logic [N*WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]     sel_out;
  logic                 busy;
  logic                 retarget;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int               lane;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_exp;
  logic mon_bad;
  int   mon_lane;
  int   valid_cnt;

  dmux_dispatch_ctrl #(
    .WIDTH     (WIDTH),
    .SEL_W     (SEL_W),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .dest_sel  (dest_sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_out   (sel_out),
    .busy      (busy),
    .retarget  (retarget)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lane, input logic [WIDTH-1:0] data);
    exp_t e;
    e.lane = lane;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: dmux rule every cycle, scoreboard pop on every lane handshake.
  always @(negedge clk) begin
    if (!reset) begin
      mon_bad = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (k != int'(sel_out)) begin
          if (out_valid[k] || (out_data[k*WIDTH +: WIDTH] != '0)) mon_bad = 1'b1;
        end
      end
      check("dmux_rule", 64'(mon_bad), 64'(0));
      if (!flush && ((out_valid & out_ready) != '0)) begin
        mon_lane = -1;
        for (int k = 0; k < N; k++) begin
          if (out_valid[k]) mon_lane = k;
        end
        check("sb_nonempty", 64'(sb_q.size() > 0), 64'(1));
        if (sb_q.size() > 0 && mon_lane >= 0) begin
          mon_exp = sb_q.pop_front();
          check("xfer_lane", 64'(mon_lane), 64'(mon_exp.lane));
          check("xfer_data", 64'(out_data[mon_lane*WIDTH +: WIDTH]), 64'(mon_exp.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_sel",       64'(sel_out),   64'(0));
    check("rst_retarget",  64'(retarget),  64'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Reset mid-hold discards the word
    tick();
    mode = 1'b0;
    out_ready = 4'b0000;
    in_valid = 1'b1;
    in_data = 16'h00AA;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_busy",  64'(busy),            64'(1));
    check("hold_valid", 64'(out_valid),       64'(4'b0001));
    check("hold_data",  64'(out_data[15:0]),  64'(16'h00AA));
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready),  64'(0));
    check("rst_mid_valid",    64'(out_valid), 64'(0));
    check("rst_mid_busy",     64'(busy),      64'(0));
    check("rst_mid_sel",      64'(sel_out),   64'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready_after", 64'(in_ready),  64'(1));
    check("rst_mid_valid_after",    64'(out_valid), 64'(0));

    // Round-robin back-to-back: lanes 0,1,2,3,0
    tick();
    mode = 1'b0;
    out_ready = 4'b1111;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data = WIDTH'(i);
      push((i - 1) % 4, WIDTH'(i));
      @(negedge clk);
      check("rr_in_ready", 64'(in_ready), 64'(1));
      if (i > 1) check("rr_valid", 64'(out_valid), 64'(1 << ((i - 2) % 4)));
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rr_valid_last", 64'(out_valid), 64'(4'b0001));
    tick();
    @(negedge clk);
    check("rr_idle", 64'(busy), 64'(0));

    // Fixed destination with 20 stalled cycles
    tick();
    mode = 1'b1;
    dest_sel = 2'd2;
    out_ready = 4'b1011;
    in_valid = 1'b1;
    in_data = 16'h1234;
    push(2, 16'h1234);
    tick();
    in_valid = 1'b0;
    dest_sel = 2'd0;
    mode = 1'b0;
    valid_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("fx_in_ready", 64'(in_ready), 64'(0));
      check("fx_retarget", 64'(retarget), 64'(0));
      if (out_valid == 4'b0100) valid_cnt++;
      tick();
    end
    mode = 1'b1;
    out_ready = 4'b1111;
    @(negedge clk);
    if (out_valid == 4'b0100) valid_cnt++;
    check("fx_in_ready_release", 64'(in_ready), 64'(1));
    tick();
    @(negedge clk);
    check("fx_valid_cycles", 64'(valid_cnt), 64'(21));
    check("fx_done", 64'(out_valid), 64'(0));

    // Round-robin retarget: rr_ptr is 1, lane 1 blocked
    tick();
    mode = 1'b0;
    out_ready = 4'b1101;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    push(2, 16'hBEEF);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < STALL_MAX; c++) begin
      @(negedge clk);
      check("rt_lane1", 64'(out_valid), 64'(4'b0010));
      check("rt_no_pulse", 64'(retarget), 64'(0));
      tick();
    end
    @(negedge clk);
    check("rt_pulse", 64'(retarget), 64'(1));
    check("rt_sel",   64'(sel_out),  64'(2));
    check("rt_lane2", 64'(out_valid), 64'(4'b0100));
    tick();
    in_valid = 1'b1;
    in_data = 16'h3333;
    out_ready = 4'b1111;
    push(3, 16'h3333);
    @(negedge clk);
    check("rt_pulse_end", 64'(retarget), 64'(0));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("rt_next_lane", 64'(out_valid), 64'(4'b1000));
    tick();

    // Flush wins over a same-cycle transfer on lane 0
    out_ready = 4'b0000;
    in_valid = 1'b1;
    in_data = 16'h5555;
    tick();
    in_valid = 1'b0;
    out_ready = 4'b1111;
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 64'(in_ready), 64'(0));
    check("fl_held_lane", 64'(out_valid), 64'(4'b0001));
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fl_busy",  64'(busy),      64'(0));
    check("fl_valid", 64'(out_valid), 64'(0));
    tick();
    in_valid = 1'b1;
    in_data = 16'h6666;
    push(0, 16'h6666);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_next_lane", 64'(out_valid), 64'(4'b0001));
    tick();
    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
